// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the main data memory controller: FSM state
// encoding, transfer direction, default geometry shared with data_cache
// and the latency-counter width helper.
package data_memory_ctrl_pkg;

    // Default geometry, kept in step with the data cache's refill interface
    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LATENCY = 5;

    // Access FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } mem_state_t;

    // Direction of the transfer latched at acceptance
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    // Width of a down-counter able to hold LATENCY
    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/data_memory_ctrl_mem_array.sv
// Word storage behind the controller: synchronous write, registered read,
// whole array and read register cleared by the asynchronous reset.
module data_memory_ctrl_mem_array
    import data_memory_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Store a word on a write commit; every word reads back as zero after reset
    // NOTE: resetting a storage array forces it into flops (no SRAM macro); done
    // here because the memory must come out of reset all-zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    // Capture a word on a read commit; holds otherwise, writes leave it alone
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Main data memory controller. Serves data-cache refills and write-backs
// with a fixed DRAM-like latency: busywait is raised combinationally while a
// request is outstanding, the transfer commits LATENCY edges after
// acceptance, then busywait drops for a one-cycle acknowledge window.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_writedata,
    output logic [DATA_W-1:0] mem_readdata,
    output logic              mem_busywait
);

    localparam int               CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t        state;
    logic [CNT_W-1:0]  counter;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req;
    logic              commit;
    mem_op_t           commit_op;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;

    // Exactly one of read/write is a request; both high is ignored
    assign req          = mem_read ^ mem_write;
    assign mem_busywait = req && (state != ACK);

    // Decide whether this edge commits, and with which operands. A single-cycle
    // build commits on the acceptance edge, so it uses the live inputs.
    // NOTE: every output of this block gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        commit      = 1'b0;
        commit_op   = op_q;
        commit_addr = addr_q;
        commit_data = wdata_q;
        case (state)
            IDLE: begin
                if (req && (LATENCY == 1)) begin
                    commit      = 1'b1;
                    commit_op   = mem_write ? OP_WRITE : OP_READ;
                    commit_addr = mem_address;
                    commit_data = mem_writedata;
                end
            end
            ACCESS: begin
                if (req && (counter == '0)) begin
                    commit = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Access FSM: accept, count down the latency (abort if withdrawn), acknowledge
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, matching the hardware it describes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q    <= mem_write ? OP_WRITE : OP_READ;
                        addr_q  <= mem_address;
                        wdata_q <= mem_writedata;
                        counter <= CNT_LOAD;
                        state   <= (LATENCY == 1) ? ACK : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (counter == '0) begin
                        state <= ACK;
                    end else begin
                        counter <= counter - CNT_ONE;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    data_memory_ctrl_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clock (clock),
        .reset (reset),
        .wr_en (commit && (commit_op == OP_WRITE)),
        .rd_en (commit && (commit_op == OP_READ)),
        .addr  (commit_addr),
        .wdata (commit_data),
        .rdata (mem_readdata)
    );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a LATENCY=5 instance checked every cycle
// against a transaction-level model, plus a LATENCY=1 instance checked with
// hand-computed values. Inputs change 1ns after posedge; outputs are
// compared on negedge.
module tb_data_memory_ctrl;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int LAT = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_address = '0;
    logic [DW-1:0] mem_writedata = '0;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;

    logic          r1 = 1'b0;
    logic          w1 = 1'b0;
    logic [AW-1:0] a1 = '0;
    logic [DW-1:0] d1 = '0;
    logic [DW-1:0] rdata1;
    logic          busy1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    data_memory_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    data_memory_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (r1),
        .mem_write     (w1),
        .mem_address   (a1),
        .mem_writedata (d1),
        .mem_readdata  (rdata1),
        .mem_busywait  (busy1)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A request accepted at edge number k commits at edge k+LAT; the edge after
    // the commit is the acknowledge cycle. Withdrawing the request before the
    // commit edge cancels it.
    logic [DW-1:0] mem_m [1 << AW];
    logic [DW-1:0] rd_m = '0;
    int            edge_n = 0;
    int            commit_edge = 0;
    bit            pending_m = 1'b0;
    bit            ack_m = 1'b0;
    bit            wr_m = 1'b0;
    logic [AW-1:0] a_m = '0;
    logic [DW-1:0] d_m = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_m = 1'b0;
            ack_m     = 1'b0;
            rd_m      = '0;
            for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
        end else begin
            edge_n++;
            if (ack_m) begin
                ack_m = 1'b0;
            end else if (pending_m) begin
                if (!(mem_read ^ mem_write)) begin
                    pending_m = 1'b0;
                end else if (edge_n == commit_edge) begin
                    if (wr_m) mem_m[a_m] = d_m;
                    else      rd_m = mem_m[a_m];
                    pending_m = 1'b0;
                    ack_m     = 1'b1;
                end
            end else if (mem_read ^ mem_write) begin
                wr_m        = mem_write;
                a_m         = mem_address;
                d_m         = mem_writedata;
                commit_edge = edge_n + LAT;
                pending_m   = 1'b1;
            end
        end
    end

    // Per-cycle comparison of the LATENCY=5 instance against the model
    always @(negedge clock) begin
        check("busywait", {31'b0, mem_busywait}, {31'b0, (mem_read ^ mem_write) && !ack_m});
        check("readdata", mem_readdata, rd_m);
    end

    // One complete access, cache-style: raise the request, hold it until
    // busywait is seen low, drop it after the following edge.
    task automatic do_access(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input bit scramble, output int busy_cnt, output logic [DW-1:0] rd_at_ack);
        @(posedge clock); #1;
        mem_read      = !wr;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = data;
        busy_cnt      = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!mem_busywait) break;
            busy_cnt++;
            if (scramble && busy_cnt == 3) begin
                @(posedge clock); #1;
                mem_address   = 6'h00;
                mem_writedata = 32'h0000_0001;
            end
        end
        check("busy_fell", {31'b0, mem_busywait}, 32'd0);
        rd_at_ack = mem_readdata;
        @(posedge clock); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            bc;
        logic [DW-1:0] rd;

        repeat (3) @(negedge clock);
        check("reset_readdata", mem_readdata, 32'h0);
        check("reset_busywait", {31'b0, mem_busywait}, 32'd0);
        @(posedge clock); #3;
        reset = 1'b1;

        // Read of a cleared word: one waiting cycle plus LAT busy cycles after acceptance
        do_access(1'b0, 6'h05, '0, 1'b0, bc, rd);
        check("rd05_busy_after_accept", bc - 1, 32'd5);
        check("rd05_data", rd, 32'h0);

        // Write then read back
        do_access(1'b1, 6'h2A, 32'hDEADBEEF, 1'b0, bc, rd);
        check("wr2a_readdata_untouched", rd, 32'h0);
        do_access(1'b0, 6'h2A, '0, 1'b0, bc, rd);
        check("rd2a_busy_after_accept", bc - 1, 32'd5);
        check("rd2a_data", rd, 32'hDEADBEEF);

        // Seed 0x00, then a write to 0x10 whose inputs change mid-access
        do_access(1'b1, 6'h00, 32'h00C0FFEE, 1'b0, bc, rd);
        check("wr00_readdata_holds", rd, 32'hDEADBEEF);
        do_access(1'b1, 6'h10, 32'hA5A5A5A5, 1'b1, bc, rd);
        do_access(1'b0, 6'h10, '0, 1'b0, bc, rd);
        check("rd10_latched_data", rd, 32'hA5A5A5A5);
        do_access(1'b0, 6'h00, '0, 1'b0, bc, rd);
        check("rd00_unchanged", rd, 32'h00C0FFEE);

        // Read withdrawn after two busy cycles past acceptance
        @(posedge clock); #1;
        mem_read    = 1'b1;
        mem_address = 6'h2A;
        bc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (mem_busywait) bc++;
        end
        check("abort_busy_before_drop", bc, 32'd3);
        @(posedge clock); #1;
        mem_read = 1'b0;
        @(negedge clock);
        check("abort_busy_low", {31'b0, mem_busywait}, 32'd0);
        check("abort_readdata_kept", mem_readdata, 32'h00C0FFEE);
        do_access(1'b0, 6'h10, '0, 1'b0, bc, rd);
        check("after_abort_busy", bc - 1, 32'd5);
        check("after_abort_data", rd, 32'hA5A5A5A5);

        // Both strobes high: no request, no access
        @(posedge clock); #1;
        mem_read      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = 6'h2A;
        mem_writedata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("both_high_busy", {31'b0, mem_busywait}, 32'd0);
        end
        @(posedge clock); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        do_access(1'b0, 6'h2A, '0, 1'b0, bc, rd);
        check("both_high_no_write", rd, 32'hDEADBEEF);

        // Reset in the middle of a write to 0x3F
        @(posedge clock); #1;
        mem_write     = 1'b1;
        mem_address   = 6'h3F;
        mem_writedata = 32'h11111111;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_busy_follows_req", {31'b0, mem_busywait}, 32'd1);
        check("rst_readdata_clear", mem_readdata, 32'h0);
        @(posedge clock); #1;
        mem_write = 1'b0;
        #1;
        check("rst_busy_low_no_req", {31'b0, mem_busywait}, 32'd0);
        @(posedge clock); #3;
        reset = 1'b1;
        do_access(1'b0, 6'h3F, '0, 1'b0, bc, rd);
        check("rd3f_after_reset", rd, 32'h0);
        do_access(1'b0, 6'h2A, '0, 1'b0, bc, rd);
        check("rd2a_after_reset", rd, 32'h0);

        // LATENCY=1 instance: commit on the acceptance edge, back-to-back write then read
        @(posedge clock); #1;
        w1 = 1'b1;
        a1 = 6'h07;
        d1 = 32'h12345678;
        @(negedge clock);
        check("l1_wr_busy_before_accept", {31'b0, busy1}, 32'd1);
        @(negedge clock);
        check("l1_wr_ack", {31'b0, busy1}, 32'd0);
        check("l1_wr_readdata_untouched", rdata1, 32'h0);
        @(posedge clock); #1;
        w1 = 1'b0;
        r1 = 1'b1;
        @(negedge clock);
        check("l1_rd_idle_cycle_busy", {31'b0, busy1}, 32'd1);
        @(negedge clock);
        check("l1_rd_ack", {31'b0, busy1}, 32'd0);
        check("l1_rd_data", rdata1, 32'h12345678);
        @(posedge clock); #1;
        r1 = 1'b0;
        @(negedge clock);
        check("l1_idle_busy", {31'b0, busy1}, 32'd0);
        check("l1_readdata_holds", rdata1, 32'h12345678);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
